// File: rtl/mdu_iter_pkg.sv
// ============================================================================
// Module   : mdu_iter_pkg
// Brief    : Opcode and FSM state encodings shared by the iterative MDU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_iter_pkg;

    localparam logic [1:0] c_OP_MULU = 2'b00;
    localparam logic [1:0] c_OP_MUL  = 2'b01;
    localparam logic [1:0] c_OP_DIVU = 2'b10;
    localparam logic [1:0] c_OP_DIV  = 2'b11;

    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_CALC = 2'b01;
    localparam logic [1:0] c_ST_FIX  = 2'b10;
    localparam logic [1:0] c_ST_DONE = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mdu_neg.sv
// ============================================================================
// Module   : mdu_neg
// Brief    : Conditional two's-complement negate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_neg
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_neg_en,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = i_neg_en ? (~i_data + {{(WIDTH-1){1'b0}}, 1'b1}) : i_data;

endmodule

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative multiply/divide unit (MULU, MUL, DIVU, DIV), {hi,lo} result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_by_zero_o
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_acc;      // mul: {partial hi, multiplier}; div: quotient in low half
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_opnd;     // multiplicand or divisor magnitude
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [2*WIDTH-1:0]   r_pend;
    logic                 r_dbz_pend;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_dbz;

    logic                 w_accept;
    logic                 w_sa;
    logic                 w_sb;
    logic                 w_div_zero;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_accept   = (r_state == c_ST_IDLE) & start_i & ~annul_i;
    assign w_sa       = op_i[0] & opdata1_i[WIDTH-1];
    assign w_sb       = op_i[0] & opdata2_i[WIDTH-1];
    assign w_div_zero = op_i[1] & (opdata2_i == '0);

    mdu_neg #(.WIDTH(WIDTH)) u_neg_a (
        .i_data   (opdata1_i),
        .i_neg_en (w_sa),
        .o_data   (w_abs_a)
    );

    mdu_neg #(.WIDTH(WIDTH)) u_neg_b (
        .i_data   (opdata2_i),
        .i_neg_en (w_sb),
        .o_data   (w_abs_b)
    );

    mdu_neg #(.WIDTH(2*WIDTH)) u_neg_prod (
        .i_data   (r_acc),
        .i_neg_en (r_neg_q),
        .o_data   (w_prod_fix)
    );

    mdu_neg #(.WIDTH(WIDTH)) u_neg_quot (
        .i_data   (r_acc[WIDTH-1:0]),
        .i_neg_en (r_neg_q),
        .o_data   (w_quot_fix)
    );

    mdu_neg #(.WIDTH(WIDTH)) u_neg_rem (
        .i_data   (r_rem),
        .i_neg_en (r_neg_r),
        .o_data   (w_rem_fix)
    );

    // Shift-add step and restoring-divide step; a borrow out of bit WIDTH means "does not fit".
    assign w_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_opnd};
    assign w_ge    = ~w_diff[WIDTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= c_ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_next = w_div_zero ? c_ST_DONE : c_ST_CALC;
            c_ST_CALC: if (annul_i) w_next = c_ST_IDLE;
                       else if (r_cnt == c_CNT_LAST) w_next = c_ST_FIX;
            c_ST_FIX:  w_next = annul_i ? c_ST_IDLE : c_ST_DONE;
            c_ST_DONE: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = 1'b0;
        ready_o = 1'b0;
        case (r_state)
            c_ST_CALC,
            c_ST_FIX:  busy_o  = 1'b1;
            c_ST_DONE: ready_o = ~annul_i;
            default:   ;
        endcase
    end

    // The new result is only exposed while it is being handed over; an annul keeps the old one.
    assign result_o      = ready_o ? r_pend     : r_result;
    assign div_by_zero_o = ready_o ? r_dbz_pend : r_dbz;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_pend     <= '0;
            r_dbz_pend <= 1'b0;
            r_result   <= '0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_is_div   <= op_i[1];
                        r_opnd     <= op_i[1] ? w_abs_b : w_abs_a;
                        r_acc      <= {{WIDTH{1'b0}}, (op_i[1] ? w_abs_a : w_abs_b)};
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_neg_q    <= w_sa ^ w_sb;
                        r_neg_r    <= w_sa;
                        r_dbz      <= 1'b0;
                        r_dbz_pend <= w_div_zero;
                        if (w_div_zero) r_pend <= {opdata1_i, {WIDTH{1'b1}}};
                    end
                end
                c_ST_CALC: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_is_div) begin
                        r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= {w_add, r_acc[WIDTH-1:1]};
                    end
                end
                c_ST_FIX: begin
                    r_pend <= r_is_div ? {w_rem_fix, w_quot_fix} : w_prod_fix;
                end
                c_ST_DONE: begin
                    if (!annul_i) begin
                        r_result <= r_pend;
                        r_dbz    <= r_dbz_pend;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Directed, table-driven self-checking bench for mdu_iter (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int c_W = 32;

    logic              clk;
    logic              resetn;
    logic              start_i;
    logic [1:0]        op_i;
    logic [c_W-1:0]    opdata1_i;
    logic [c_W-1:0]    opdata2_i;
    logic              annul_i;
    logic              busy_o;
    logic              ready_o;
    logic [2*c_W-1:0]  result_o;
    logic              div_by_zero_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    logic [2*c_W-1:0] last_res;

    mdu_iter #(.WIDTH(c_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start_i       (start_i),
        .op_i          (op_i),
        .opdata1_i     (opdata1_i),
        .opdata2_i     (opdata2_i),
        .annul_i       (annul_i),
        .busy_o        (busy_o),
        .ready_o       (ready_o),
        .result_o      (result_o),
        .div_by_zero_o (div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]       op;
        logic [c_W-1:0]   a;
        logic [c_W-1:0]   b;
        logic [2*c_W-1:0] res;
        logic             dbz;
        int               lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [c_W-1:0] a,
                         input logic [c_W-1:0] b, input logic [2*c_W-1:0] exp_res,
                         input logic exp_dbz, input int exp_lat);
        logic             found;
        int               lat;
        logic [2*c_W-1:0] got_res;
        logic             got_dbz;
        found = 1'b0; lat = 0; got_res = '0; got_dbz = 1'b0;
        @(negedge clk);
        start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
        @(negedge clk);
        start_i = 1'b0; op_i = 2'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
        for (int k = 1; k <= 60; k++) begin
            if (k == 1 && exp_lat != 1) begin
                chk({tag, "_busy"}, 64'(busy_o), 64'd1);
                chk({tag, "_dbz_clr"}, 64'(div_by_zero_o), 64'd0);
                chk({tag, "_held"}, result_o, last_res);
            end
            if (ready_o) begin
                found = 1'b1; lat = k; got_res = result_o; got_dbz = div_by_zero_o;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
            chk({tag, "_res"}, got_res, exp_res);
            chk({tag, "_dbz"}, 64'(got_dbz), 64'(exp_dbz));
            @(negedge clk);
            chk({tag, "_pulse"}, 64'(ready_o), 64'd0);
            chk({tag, "_hold"}, result_o, exp_res);
        end
        last_res = exp_res;
    endtask

    initial begin
        logic seen;
        int   t[3];
        logic [2*c_W-1:0] r[3];
        int   npulse;

        vecs[0]  = '{c_OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 34};
        vecs[1]  = '{c_OP_MUL,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 34};
        vecs[2]  = '{c_OP_DIV,  32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 34};
        vecs[3]  = '{c_OP_DIVU, 32'h00000007, 32'h00000002, 64'h00000001_00000003, 1'b0, 34};
        vecs[4]  = '{c_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 34};
        vecs[5]  = '{c_OP_DIVU, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF, 1'b1, 1};
        vecs[6]  = '{c_OP_DIV,  32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF, 1'b1, 1};
        vecs[7]  = '{c_OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0, 34};
        vecs[8]  = '{c_OP_MULU, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 1'b0, 34};
        vecs[9]  = '{c_OP_DIV,  32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 34};
        vecs[10] = '{c_OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 1'b0, 34};
        vecs[11] = '{c_OP_MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 34};
        vecs[12] = '{c_OP_DIVU, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 1'b0, 34};
        vecs[13] = '{c_OP_MULU, 32'h12345678, 32'h00000000, 64'h00000000_00000000, 1'b0, 34};
        vecs[14] = '{c_OP_DIVU, 32'h00000064, 32'h00000007, 64'h00000002_0000000E, 1'b0, 34};

        resetn = 1'b0; start_i = 1'b0; op_i = '0; opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
        last_res = '0;
        #2;
        chk("rst_busy",  64'(busy_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_res",   result_o, 64'd0);
        chk("rst_dbz",   64'(div_by_zero_o), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 15; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].dbz, vecs[i].lat);

        // Annul mid-DIV: aborts silently and keeps the committed result.
        @(negedge clk);
        start_i = 1'b1; op_i = c_OP_DIV; opdata1_i = 32'hFFFFFF9C; opdata2_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        seen = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (ready_o) seen = 1'b1;
            @(negedge clk);
        end
        chk("annul_busy_before", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        @(negedge clk);
        chk("annul_busy_c12", 64'(busy_o), 64'd0);
        for (int k = 0; k < 40; k++) begin
            if (ready_o) seen = 1'b1;
            @(negedge clk);
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        chk("annul_res_held", result_o, last_res);
        do_op("after_annul", c_OP_DIVU, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, 34);

        // Annul together with start in IDLE drops the request.
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; op_i = c_OP_MULU; opdata1_i = 32'd2; opdata2_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        chk("annul_idle_busy", 64'(busy_o), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (ready_o) seen = 1'b1;
            @(negedge clk);
        end
        chk("annul_idle_no_ready", 64'(seen), 64'd0);
        chk("annul_idle_res", result_o, last_res);

        // Held start: back-to-back ops, operands changed while busy must not disturb op 1.
        @(negedge clk);
        start_i = 1'b1; op_i = c_OP_MULU; opdata1_i = 32'd3; opdata2_i = 32'd5;
        npulse = 0;
        for (int k = 0; k < 150 && npulse < 3; k++) begin
            @(negedge clk);
            if (k == 5) begin opdata1_i = 32'd2; opdata2_i = 32'd2; end
            if (ready_o) begin
                t[npulse] = cyc; r[npulse] = result_o; npulse++;
                if (npulse == 3) start_i = 1'b0;
            end
        end
        chk("b2b_pulses", 64'(npulse), 64'd3);
        if (npulse == 3) begin
            chk("b2b_res0", r[0], 64'd15);
            chk("b2b_res1", r[1], 64'd4);
            chk("b2b_res2", r[2], 64'd4);
            chk("b2b_gap0", 64'(t[1] - t[0]), 64'd35);
            chk("b2b_gap1", 64'(t[2] - t[1]), 64'd35);
        end
        @(negedge clk);
        @(negedge clk);
        chk("b2b_stopped", 64'(busy_o), 64'd0);
        last_res = 64'd4;

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start_i = 1'b1; op_i = c_OP_MULU; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'hFFFFFFFF;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        chk("arst_busy_before", 64'(busy_o), 64'd1);
        chk("arst_res_before", result_o, last_res);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy",  64'(busy_o), 64'd0);
        chk("arst_ready", 64'(ready_o), 64'd0);
        chk("arst_res",   result_o, 64'd0);
        chk("arst_dbz",   64'(div_by_zero_o), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        last_res = '0;
        do_op("after_rst", c_OP_MUL, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
